// File: rtl/npc_pkg.sv
// Shared next-PC opcode encodings and default address map for the fetch stage and control decoder.
package npc_pkg;

   typedef logic [2:0] npc_op_t;

   localparam npc_op_t NOP_SEQ = 3'b000;
   localparam npc_op_t BR      = 3'b001;
   localparam npc_op_t J       = 3'b010;
   localparam npc_op_t JR      = 3'b011;
   localparam npc_op_t JAL     = 3'b101;
   localparam npc_op_t JALR    = 3'b111;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
   localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;
   localparam logic [31:0] IM_BASE_DEF  = 32'h0000_3000;
   localparam int          IM_WORDS_DEF = 4096;

endpackage

// File: rtl/npc_sel.sv
// Combinational next-PC mux: sequential, taken branch, j/jal region jump, jr/jalr register target.
// Zero latency, no state; reserved opcodes fall back to sequential fetch.
module npc_sel
   import npc_pkg::*;
#(
   parameter int PC_W = 32
) (
   input  logic [2:0]      d_npc_op,
   input  logic            d_cmp,
   input  logic [25:0]     d_imm26,
   input  logic [PC_W-1:0] d_pc,
   input  logic [PC_W-1:0] d_rs,
   input  logic [PC_W-1:0] f_pc,
   output logic [PC_W-1:0] npc
);

   logic [PC_W-1:0] seq_pc;
   logic [PC_W-1:0] br_off;
   logic [PC_W-1:0] br_pc;
   logic [PC_W-1:0] jmp_pc;

   assign seq_pc = f_pc + PC_W'(4);
   // Word offset: imm16 shifted left two and sign-extended from bit 17.
   assign br_off = {{(PC_W-18){d_imm26[15]}}, d_imm26[15:0], 2'b00};
   assign br_pc  = d_pc + PC_W'(4) + br_off;
   assign jmp_pc = {d_pc[PC_W-1:28], d_imm26, 2'b00};

   always_comb begin
      npc = seq_pc;
      case (d_npc_op)
         BR:       npc = d_cmp ? br_pc : seq_pc;
         J, JAL:   npc = jmp_pc;
         JR, JALR: npc = d_rs;
         default:  npc = seq_pc;
      endcase
   end

endmodule

// File: rtl/npc_pc_unit.sv
// Fetch PC register: exception/eret redirect > stall hold > npc, with one-cycle registered flush (NPC_EXC_EN enables exc/eret, f_adel, f_flush).
// f_pc updates one cycle after selection; stall freezes it unless an exception redirects.
module npc_pc_unit
   import npc_pkg::*;
#(
   parameter int              PC_W     = 32,
   parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF,
   parameter logic [PC_W-1:0] EXC_VEC  = EXC_VEC_DEF,
   parameter logic [PC_W-1:0] IM_BASE  = IM_BASE_DEF,
   parameter int              IM_WORDS = IM_WORDS_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic [2:0]      d_npc_op,
   input  logic            d_cmp,
   input  logic [25:0]     d_imm26,
   input  logic [PC_W-1:0] d_pc,
   input  logic [PC_W-1:0] d_rs,
   input  logic            exc_req,
   input  logic            eret_req,
   input  logic [PC_W-1:0] epc,
   output logic [PC_W-1:0] f_pc,
   output logic            f_adel,
   output logic            f_bd,
   output logic            f_flush
);

   logic [PC_W-1:0] f_pc_q;
   logic [PC_W-1:0] f_pc_d;
   logic [PC_W-1:0] npc;

   npc_sel #(.PC_W(PC_W)) u_npc_sel (
      .d_npc_op (d_npc_op),
      .d_cmp    (d_cmp),
      .d_imm26  (d_imm26),
      .d_pc     (d_pc),
      .d_rs     (d_rs),
      .f_pc     (f_pc_q),
      .npc      (npc)
   );

   assign f_pc = f_pc_q;
   assign f_bd = (d_npc_op != NOP_SEQ);

`ifdef NPC_EXC_EN
   localparam logic [PC_W-1:0] IM_SPAN = PC_W'(4 * IM_WORDS - 4);
   localparam logic [PC_W-1:0] IM_LAST = IM_BASE + IM_SPAN;

   logic f_flush_q;
   logic f_flush_d;

   // Exception beats stall; eret waits for the stall to clear since it has no delay slot.
   always_comb begin
      f_pc_d    = f_pc_q;
      f_flush_d = 1'b0;
      if (exc_req) begin
         f_pc_d    = EXC_VEC;
         f_flush_d = 1'b1;
      end else if (eret_req && !stall) begin
         f_pc_d    = epc;
         f_flush_d = 1'b1;
      end else if (!stall) begin
         f_pc_d    = npc;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         f_pc_q    <= RESET_PC;
         f_flush_q <= 1'b0;
      end else begin
         f_pc_q    <= f_pc_d;
         f_flush_q <= f_flush_d;
      end
   end

   assign f_flush = f_flush_q;
   assign f_adel  = (f_pc_q[1:0] != 2'b00) || (f_pc_q < IM_BASE) || (f_pc_q > IM_LAST);
`else
   logic unused_exc;
   assign unused_exc = &{1'b0, exc_req, eret_req, epc};

   always_comb begin
      f_pc_d = f_pc_q;
      if (!stall) f_pc_d = npc;
   end

   always_ff @(posedge clk) begin
      if (reset) f_pc_q <= RESET_PC;
      else       f_pc_q <= f_pc_d;
   end

   assign f_flush = 1'b0;
   assign f_adel  = 1'b0;
`endif

endmodule

// File: tb/tb_npc_pc_unit.sv
// Directed-vector bench for npc_pc_unit; covers both NPC_EXC_EN builds.
module tb_npc_pc_unit;
   import npc_pkg::*;

`ifdef NPC_EXC_EN
   localparam bit EXC = 1'b1;
`else
   localparam bit EXC = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic [2:0]  d_npc_op = NOP_SEQ;
   logic        d_cmp = 1'b0;
   logic [25:0] d_imm26 = '0;
   logic [31:0] d_pc = '0;
   logic [31:0] d_rs = '0;
   logic        exc_req = 1'b0;
   logic        eret_req = 1'b0;
   logic [31:0] epc = '0;
   logic [31:0] f_pc;
   logic        f_adel;
   logic        f_bd;
   logic        f_flush;

   int n_chk = 0;
   int n_pass = 0;

   npc_pc_unit dut (
      .clk      (clk),
      .reset    (reset),
      .stall    (stall),
      .d_npc_op (d_npc_op),
      .d_cmp    (d_cmp),
      .d_imm26  (d_imm26),
      .d_pc     (d_pc),
      .d_rs     (d_rs),
      .exc_req  (exc_req),
      .eret_req (eret_req),
      .epc      (epc),
      .f_pc     (f_pc),
      .f_adel   (f_adel),
      .f_bd     (f_bd),
      .f_flush  (f_flush)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Check PC, address error and flush together after an edge.
   task automatic chk_state(input string tag, input logic [31:0] pc, input logic adel, input logic flush);
      chk({tag, ".pc"}, f_pc, pc);
      chk({tag, ".adel"}, {31'd0, f_adel}, {31'd0, adel & EXC});
      chk({tag, ".flush"}, {31'd0, f_flush}, {31'd0, flush & EXC});
   endtask

   initial begin
      // Reset and free-running sequential fetch.
      step();
      chk_state("rst", 32'h3000, 1'b0, 1'b0);
      reset = 1'b0;
      chk("bd_nop", {31'd0, f_bd}, 32'd0);
      step(); chk_state("seq1", 32'h3004, 1'b0, 1'b0);
      step(); chk_state("seq2", 32'h3008, 1'b0, 1'b0);
      step(); chk_state("seq3", 32'h300C, 1'b0, 1'b0);

      // Branch taken backwards, then not taken.
      d_pc = 32'h3008; d_npc_op = BR; d_imm26 = 26'h000FFFE; d_cmp = 1'b1;
      #1 chk("bd_br_t", {31'd0, f_bd}, 32'd1);
      step(); chk_state("br_taken", 32'h3004, 1'b0, 1'b0);
      d_cmp = 1'b0;
      #1 chk("bd_br_nt", {31'd0, f_bd}, 32'd1);
      step(); chk_state("br_not", 32'h3008, 1'b0, 1'b0);

      // Misaligned jr target, then region jump.
      d_npc_op = JR; d_rs = 32'h3402;
      step(); chk_state("jr_mis", 32'h3402, 1'b1, 1'b0);
      d_npc_op = J; d_imm26 = 26'h0000D00;
      step(); chk_state("j", 32'h3400, 1'b0, 1'b0);

      // Stall freezes the PC; release takes the jump.
      stall = 1'b1; d_imm26 = 26'h0000D40;
      for (int i = 0; i < 3; i++) begin
         step(); chk("stall_hold", f_pc, 32'h3400);
      end
      stall = 1'b0;
      step(); chk_state("stall_rel", 32'h3500, 1'b0, 1'b0);

      // Address-range boundaries and silent wrap.
      d_npc_op = JR; d_rs = 32'h6FFC;
      step(); chk_state("adel_last", 32'h6FFC, 1'b0, 1'b0);
      d_npc_op = NOP_SEQ;
      step(); chk_state("adel_past", 32'h7000, 1'b1, 1'b0);
      d_npc_op = JR; d_rs = 32'hFFFF_FFFC;
      step(); chk_state("adel_top", 32'hFFFF_FFFC, 1'b1, 1'b0);
      d_npc_op = NOP_SEQ;
      step(); chk_state("wrap", 32'h0000_0000, 1'b1, 1'b0);
      d_npc_op = JR; d_rs = 32'h2FFC;
      step(); chk_state("adel_below", 32'h2FFC, 1'b1, 1'b0);
      d_rs = 32'h3000;
      step(); chk_state("adel_base", 32'h3000, 1'b0, 1'b0);
      d_npc_op = NOP_SEQ;

`ifdef NPC_EXC_EN
      // Exception overrides stall, eret redirects, both together pick the exception.
      stall = 1'b1; exc_req = 1'b1;
      step(); chk_state("exc_stall", 32'h4180, 1'b0, 1'b1);
      stall = 1'b0; exc_req = 1'b0;
      step(); chk_state("exc_after", 32'h4184, 1'b0, 1'b0);
      eret_req = 1'b1; epc = 32'h3010;
      step(); chk_state("eret", 32'h3010, 1'b0, 1'b1);
      epc = 32'h3020;
      step(); chk_state("eret_back2back", 32'h3020, 1'b0, 1'b1);
      stall = 1'b1;
      step(); chk_state("eret_stalled", 32'h3020, 1'b0, 1'b0);
      stall = 1'b0; exc_req = 1'b1;
      step(); chk_state("exc_and_eret", 32'h4180, 1'b0, 1'b1);
      reset = 1'b1;
      step(); chk_state("rst_over_exc", 32'h3000, 1'b0, 1'b0);
      reset = 1'b0; exc_req = 1'b0; eret_req = 1'b0;
`else
      // Exception inputs have no effect in the minimal build.
      exc_req = 1'b1; eret_req = 1'b1; epc = 32'h3010;
      step(); chk_state("exc_ignored", 32'h3004, 1'b0, 1'b0);
      d_npc_op = JR; d_rs = 32'h2FFC;
      step(); chk_state("no_adel", 32'h2FFC, 1'b0, 1'b0);
      chk("no_adel_raw", {31'd0, f_adel}, 32'd0);
      chk("no_flush_raw", {31'd0, f_flush}, 32'd0);
      exc_req = 1'b0; eret_req = 1'b0; d_npc_op = NOP_SEQ;
`endif

      // Reset wins over a held stall.
      stall = 1'b1; reset = 1'b1;
      step(); chk_state("rst_over_stall", 32'h3000, 1'b0, 1'b0);
      reset = 1'b0; stall = 1'b0;
      step(); chk_state("post_rst", 32'h3004, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
